// File: rtl/knapsack_load_ctrl.sv
// Knapsack front-end: debounces the confirm/release buttons, walks the operator
// through N, W, w[], p[] from the switches, launches the solver and tracks
// busy/done. Field index and staged value are exported for the display.

// Button debouncer: 2-FF sync, stability counter, one-cycle press pulse on 0->1.
module knapsack_deb #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of disagreement; flip the stable level on the last one.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        stable_d = ~stable_q;
        press_d  = ~stable_q;   // only the rising stable edge is an event
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;
endmodule

module knapsack_load_ctrl #(
  parameter int WIDTH      = 4,
  parameter int MAX_ITEMS  = 4,
  parameter int DEB_CYCLES = 250000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_signal_c,
  input  logic                       in_signal_r,
  input  logic [WIDTH-1:0]           sw,
  input  logic                       solver_done,
  output logic [WIDTH-1:0]           n_out,
  output logic [WIDTH-1:0]           cap_out,
  output logic [WIDTH*MAX_ITEMS-1:0] w_flat,
  output logic [WIDTH*MAX_ITEMS-1:0] p_flat,
  output logic                       start,
  output logic                       busy,
  output logic                       result_valid,
  output logic [3:0]                 field_idx,
  output logic [WIDTH-1:0]           staged,
  output logic                       staged_valid
);
  localparam logic [3:0] LAST = 4'(2 * MAX_ITEMS + 1);

  typedef enum logic [2:0] {
    S_LOAD, S_HOLD, S_START, S_RUN, S_DONE
  } state_t;

  // Button events: bit 0 = confirm, bit 1 = release/next.
  logic [1:0] ev;

  knapsack_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   ({in_signal_r, in_signal_c}),
    .press (ev)
  );

  wire ev_c = ev[0];
  wire ev_r = ev[1] & ~ev[0];   // confirm wins a same-cycle collision

  state_t                               state_q, state_d;
  logic [3:0]                           field_idx_q, field_idx_d;
  logic [WIDTH-1:0]                     staged_q, staged_d;
  logic                                 staged_valid_q, staged_valid_d;
  logic                                 busy_q, busy_d;
  logic                                 result_valid_q, result_valid_d;
  logic [WIDTH-1:0]                     n_q, n_d;
  logic [WIDTH-1:0]                     cap_q, cap_d;
  logic [MAX_ITEMS-1:0][WIDTH-1:0]      w_q, w_d;
  logic [MAX_ITEMS-1:0][WIDTH-1:0]      p_q, p_d;
  logic                                 commit;

  // Sequencer next-state, field commit and clear.
  always_comb begin
    state_d        = state_q;
    field_idx_d    = field_idx_q;
    staged_d       = staged_q;
    staged_valid_d = staged_valid_q;
    busy_d         = busy_q;
    result_valid_d = result_valid_q;
    n_d            = n_q;
    cap_d          = cap_q;
    w_d            = w_q;
    p_d            = p_q;
    commit         = 1'b0;
    start          = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        if (ev_c) begin
          staged_d       = sw;
          staged_valid_d = 1'b1;
          state_d        = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ev_c) begin
          staged_d = sw;
        end else if (ev_r) begin
          commit         = 1'b1;
          staged_valid_d = 1'b0;
          if (field_idx_q == LAST) begin
            state_d = S_START;
          end else begin
            field_idx_d = field_idx_q + 4'd1;
            state_d     = S_LOAD;
          end
        end
      end
      S_START: begin
        start   = 1'b1;
        busy_d  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (solver_done) begin
          busy_d         = 1'b0;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_DONE: begin
        if (ev_r) begin
          result_valid_d = 1'b0;
          field_idx_d    = 4'd0;
          n_d            = '0;
          cap_d          = '0;
          w_d            = '0;
          p_d            = '0;
          state_d        = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase

    // Field index decode: 0=N, 1=W, then weights, then prices.
    if (commit) begin
      if (field_idx_q == 4'd0) n_d = staged_q;
      if (field_idx_q == 4'd1) cap_d = staged_q;
      for (int i = 0; i < MAX_ITEMS; i++) begin
        if (field_idx_q == 4'(i + 2))             w_d[i] = staged_q;
        if (field_idx_q == 4'(i + 2 + MAX_ITEMS)) p_d[i] = staged_q;
      end
    end
  end

  // Sequencer and problem registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_LOAD;
      field_idx_q    <= 4'd0;
      staged_q       <= '0;
      staged_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      n_q            <= '0;
      cap_q          <= '0;
      w_q            <= '0;
      p_q            <= '0;
    end else begin
      state_q        <= state_d;
      field_idx_q    <= field_idx_d;
      staged_q       <= staged_d;
      staged_valid_q <= staged_valid_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      n_q            <= n_d;
      cap_q          <= cap_d;
      w_q            <= w_d;
      p_q            <= p_d;
    end
  end

  assign n_out        = n_q;
  assign cap_out      = cap_q;
  assign w_flat       = w_q;
  assign p_flat       = p_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign field_idx    = field_idx_q;
  assign staged       = staged_q;
  assign staged_valid = staged_valid_q;
endmodule

// File: tb/tb_knapsack_load_ctrl.sv
// Directed bench for knapsack_load_ctrl with a short debounce window.
module tb_knapsack_load_ctrl;
  localparam int WIDTH = 4;
  localparam int MI    = 4;
  localparam int DEB   = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_signal_c, in_signal_r, solver_done;
  logic [WIDTH-1:0]        sw;
  logic [WIDTH-1:0]        n_out, cap_out, staged;
  logic [WIDTH*MI-1:0]     w_flat, p_flat;
  logic                    start, busy, result_valid, staged_valid;
  logic [3:0]              field_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  knapsack_load_ctrl #(.WIDTH(WIDTH), .MAX_ITEMS(MI), .DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_signal_c  (in_signal_c),
    .in_signal_r  (in_signal_r),
    .sw           (sw),
    .solver_done  (solver_done),
    .n_out        (n_out),
    .cap_out      (cap_out),
    .w_flat       (w_flat),
    .p_flat       (p_flat),
    .start        (start),
    .busy         (busy),
    .result_valid (result_valid),
    .field_idx    (field_idx),
    .staged       (staged),
    .staged_valid (staged_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the chosen button(s) long enough for a press, then long enough for release.
  task automatic press(input bit do_c, input bit do_r, input logic [3:0] v);
    sw          = v;
    in_signal_c = do_c;
    in_signal_r = do_r;
    repeat (8) @(negedge clk);
    in_signal_c = 1'b0;
    in_signal_r = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  logic [3:0] vals1 [6];
  logic [3:0] vals2 [10];

  initial begin
    vals1 = '{4'd4, 4'd4, 4'd2, 4'd15, 4'd4, 4'd6};
    vals2 = '{4'd3, 4'd7, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    rst_n = 1'b0; in_signal_c = 1'b0; in_signal_r = 1'b0; solver_done = 1'b0; sw = '0;
    repeat (2) @(negedge clk);
    chk("rst_n_out", n_out, 0);
    chk("rst_cap", cap_out, 0);
    chk("rst_w", w_flat, 0);
    chk("rst_p", p_flat, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_fidx", field_idx, 0);
    chk("rst_staged", staged, 0);
    chk("rst_sv", staged_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3-cycle glitch must not produce an event
    sw = 4'd9; in_signal_c = 1'b1;
    repeat (3) @(negedge clk);
    in_signal_c = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_sv", staged_valid, 0);

    // 6-cycle pulse: event after DEB+2 edges, captured one edge later
    sw = 4'd12; in_signal_c = 1'b1;
    repeat (6) @(negedge clk);
    chk("deb_early", staged_valid, 0);
    in_signal_c = 1'b0;
    @(negedge clk);
    chk("deb_sv", staged_valid, 1);
    chk("deb_staged", staged, 12);
    sw = 4'd7;
    repeat (10) @(negedge clk);
    chk("no_release_ev", staged, 12);
    chk("hold_fidx", field_idx, 0);

    press(0, 1, 4'd0);
    chk("commit_n", n_out, 12);
    chk("fidx1", field_idx, 1);
    chk("commit_sv", staged_valid, 0);

    // r in LOAD with nothing staged is ignored
    press(0, 1, 4'd0);
    chk("r_in_load_fidx", field_idx, 1);
    chk("r_in_load_cap", cap_out, 0);

    // recapture in HOLD
    press(1, 0, 4'd3);
    chk("cap_stage1", staged, 3);
    press(1, 0, 4'd10);
    chk("cap_stage2", staged, 10);
    press(0, 1, 4'd0);
    chk("cap_commit", cap_out, 10);
    chk("fidx2", field_idx, 2);

    // simultaneous c and r in HOLD: capture, no commit
    press(1, 0, 4'd6);
    press(1, 1, 4'd5);
    chk("sim_staged", staged, 5);
    chk("sim_fidx", field_idx, 2);
    chk("sim_w", w_flat, 0);
    chk("sim_sv", staged_valid, 1);
    press(1, 0, 4'd6);
    press(0, 1, 4'd0);
    chk("w0_commit", w_flat, 16'h0006);

    for (int i = 0; i < 6; i++) begin
      press(1, 0, vals1[i]);
      press(0, 1, 4'd0);
    end
    chk("fidx_last", field_idx, 9);
    press(1, 0, 4'd1);

    // final release: watch the start pulse
    sw = 4'd0; in_signal_r = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_start", start, 0);
    @(negedge clk);
    chk("start_hi", start, 1);
    chk("start_busy", busy, 0);
    @(negedge clk);
    chk("start_lo", start, 0);
    chk("run_busy", busy, 1);
    chk("run_n", n_out, 4'hC);
    chk("run_cap", cap_out, 4'hA);
    chk("run_w", w_flat, 16'h2446);
    chk("run_p", p_flat, 16'h164F);
    chk("run_fidx", field_idx, 9);
    in_signal_r = 1'b0;
    repeat (8) @(negedge clk);

    // buttons ignored in RUN
    press(1, 0, 4'd3);
    chk("run_c_busy", busy, 1);
    chk("run_c_staged", staged, 1);
    chk("run_c_sv", staged_valid, 0);

    solver_done = 1'b1;
    @(negedge clk);
    solver_done = 1'b0;
    chk("done_busy", busy, 0);
    chk("done_rv", result_valid, 1);
    chk("done_n", n_out, 4'hC);

    press(1, 0, 4'd3);
    chk("done_c_rv", result_valid, 1);
    chk("done_c_sv", staged_valid, 0);
    press(0, 1, 4'd0);
    chk("clr_rv", result_valid, 0);
    chk("clr_fidx", field_idx, 0);
    chk("clr_w", w_flat, 0);
    chk("clr_p", p_flat, 0);
    chk("clr_n", n_out, 0);
    chk("clr_cap", cap_out, 0);

    // second load, then reset in RUN
    for (int i = 0; i < 10; i++) begin
      press(1, 0, vals2[i]);
      press(0, 1, 4'd0);
    end
    chk("l2_busy", busy, 1);
    chk("l2_n", n_out, 3);
    chk("l2_w", w_flat, 16'h4321);
    chk("l2_p", p_flat, 16'h8765);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_fidx", field_idx, 0);
    chk("arst_n", n_out, 0);
    chk("arst_cap", cap_out, 0);
    chk("arst_w", w_flat, 0);
    chk("arst_p", p_flat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    solver_done = 1'b1;
    @(negedge clk);
    solver_done = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rv", result_valid, 0);
    press(1, 0, 4'd5);
    chk("post_rst_sv", staged_valid, 1);
    chk("post_rst_staged", staged, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
